// File: rtl/aurora_nfc_sim_pkg.sv
// Shared types for the bench-side Aurora NFC partner: request layout, FSM states
// and the request decoder.
package aurora_nfc_sim_pkg;

    localparam int unsigned NfcDataW = 16;

    typedef struct packed {
        logic [6:0] reserved;
        logic       xoff;
        logic [7:0] pause_duration;
    } nfc_request_t;

    typedef enum logic [1:0] {
        StRun,
        StPause,
        StStop
    } nfc_sim_state_t;

    typedef enum logic [1:0] {
        CmdStop,
        CmdXon,
        CmdPause
    } nfc_cmd_t;

    // Reserved bits play no part in decode; they only feed the protocol error flag.
    function automatic nfc_cmd_t nfc_decode(input nfc_request_t req);
        nfc_cmd_t cmd;
        if (req.xoff) begin
            cmd = CmdStop;
        end else if (req.pause_duration == 8'd0) begin
            cmd = CmdXon;
        end else begin
            cmd = CmdPause;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/nfc_sim_pipelined_if.sv
// NFC request channel between the Aurora DUT (master) and the bench-side NFC partner (slave).
interface nfc_sim_pipelined_if;
    import aurora_nfc_sim_pkg::*;

    logic                s_axi_nfc_tvalid;
    logic [NfcDataW-1:0] s_axi_nfc_tdata;
    logic                s_axi_nfc_tready;

    modport master (
        output s_axi_nfc_tvalid,
        output s_axi_nfc_tdata,
        input  s_axi_nfc_tready
    );

    modport slave (
        input  s_axi_nfc_tvalid,
        input  s_axi_nfc_tdata,
        output s_axi_nfc_tready
    );

endinterface

// File: rtl/nfc_req_delay_queue.sv
// Circular FIFO of accepted NFC requests, each tagged with the timestamp it was queued at.
// A pop frees the head slot before a same-cycle push, so push+pop works even when full.
module nfc_req_delay_queue
    import aurora_nfc_sim_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TS_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  nfc_request_t             push_req,
    input  logic [TS_W-1:0]          push_ts,
    input  logic                     pop,
    output nfc_request_t             head_req,
    output logic [TS_W-1:0]          head_ts,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    typedef struct packed {
        nfc_request_t    req;
        logic [TS_W-1:0] ts;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PtrW + 1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_req = mem_q[rd_ptr_q].req;
    assign head_ts  = mem_q[rd_ptr_q].ts;
    assign count    = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
        end
    end

    // Storage needs no reset: count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= '{req: push_req, ts: push_ts};
        end
    end

endmodule

// File: rtl/nfc_sim_pipelined.sv
// Bench-side Aurora NFC partner: holds each accepted request for NFC_DELAY cycles, then applies it
// to a RUN/PAUSE/STOP machine whose registered state drives stall_transmission.
module nfc_sim_pipelined
    import aurora_nfc_sim_pkg::*;
#(
    parameter int unsigned NFC_DELAY    = 16,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned PAUSE_UNIT   = 1,
    parameter int unsigned TREADY_GAP   = 1,
    parameter int unsigned STAT_W       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    nfc_sim_pipelined_if.slave            nfc,
    output logic                          stall_transmission,
    output logic [$clog2(MAX_INFLIGHT):0] inflight_count,
    output logic [STAT_W-1:0]             stall_cycles,
    input  logic                          stat_clear,
    output logic                          protocol_error
);

    localparam int unsigned CntW   = 8 + $clog2(PAUSE_UNIT) + 1;
    localparam int unsigned GapW   = $clog2(TREADY_GAP + 2);
    localparam int unsigned CountW = $clog2(MAX_INFLIGHT) + 1;

    nfc_request_t      acc_req;
    nfc_request_t      head_req;
    logic [STAT_W-1:0] head_ts;
    logic              q_empty;
    logic              q_full;
    logic [CountW-1:0] q_count;
    logic [STAT_W-1:0] now_q;
    logic [GapW-1:0]   gap_q;
    nfc_sim_state_t    state_q;
    logic [CntW-1:0]   cnt_q;
    logic              stall_q;
    logic              err_q;
    logic [STAT_W-1:0] stall_cycles_q;
    logic              accept;
    logic              due;
    nfc_cmd_t          head_cmd;
    logic [CntW-1:0]   pause_load;

    assign acc_req    = nfc_request_t'(nfc.s_axi_nfc_tdata);
    assign head_cmd   = nfc_decode(head_req);
    assign pause_load = CntW'(head_req.pause_duration) * CntW'(PAUSE_UNIT);

    // Modular subtraction keeps the due test correct across timestamp wrap.
    assign due = !q_empty && ((now_q - head_ts) >= STAT_W'(NFC_DELAY));

    // A due head frees its slot this edge, so a full queue may still accept.
    assign nfc.s_axi_nfc_tready = (gap_q == '0) && (!q_full || due);
    assign accept               = nfc.s_axi_nfc_tvalid && nfc.s_axi_nfc_tready;

    // Entries carry the timestamp of the first cycle they sit in the queue, which places the
    // application edge exactly NFC_DELAY+1 edges after the accept edge.
    nfc_req_delay_queue #(
        .DEPTH (MAX_INFLIGHT),
        .TS_W  (STAT_W)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_req (acc_req),
        .push_ts  (now_q + STAT_W'(1)),
        .pop      (due),
        .head_req (head_req),
        .head_ts  (head_ts),
        .empty    (q_empty),
        .full     (q_full),
        .count    (q_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            now_q <= '0;
            gap_q <= '0;
        end else begin
            now_q <= now_q + STAT_W'(1);
            if (accept) begin
                gap_q <= GapW'(TREADY_GAP);
            end else if (gap_q != '0) begin
                gap_q <= gap_q - GapW'(1);
            end
        end
    end

    // A popped request takes priority over pause expiry on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else if (due) begin
            case (head_cmd)
                CmdStop: begin
                    state_q <= StStop;
                    stall_q <= 1'b1;
                end
                CmdXon: begin
                    state_q <= StRun;
                    stall_q <= 1'b0;
                end
                CmdPause: begin
                    if (state_q != StStop) begin
                        state_q <= StPause;
                        cnt_q   <= pause_load;
                        stall_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end else if (state_q == StPause) begin
            if (cnt_q <= CntW'(1)) begin
                state_q <= StRun;
                stall_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            err_q          <= 1'b0;
        end else begin
            if (stat_clear) begin
                stall_cycles_q <= '0;
            end else if (stall_q && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + STAT_W'(1);
            end
            if (stat_clear) begin
                err_q <= 1'b0;
            end else if (accept && (acc_req.reserved != '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign stall_transmission = stall_q;
    assign inflight_count     = q_count;
    assign stall_cycles       = stall_cycles_q;
    assign protocol_error     = err_q;

endmodule

// File: tb/tb_nfc_sim_pipelined.sv
// Self-checking bench for nfc_sim_pipelined: scoreboard of accepted requests plus a timeline
// model of the stall state, with fixed-point checks on the documented scenarios.
module tb_nfc_sim_pipelined;

    localparam int unsigned D     = 16;
    localparam int unsigned PU    = 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SW    = 32;
    localparam int M_RUN   = 0;
    localparam int M_PAUSE = 1;
    localparam int M_STOP  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nfc_sim_pipelined_if nfc_a ();
    nfc_sim_pipelined_if nfc_b ();

    logic          stall_a, stall_b, err_a, err_b, clr_a, clr_b;
    logic [2:0]    inf_a, inf_b;
    logic [SW-1:0] sc_a, sc_b;

    nfc_sim_pipelined #(
        .NFC_DELAY(D), .MAX_INFLIGHT(DEPTH), .PAUSE_UNIT(PU), .TREADY_GAP(1), .STAT_W(SW)
    ) u_dut_a (
        .clk(clk), .rst(rst), .nfc(nfc_a), .stall_transmission(stall_a),
        .inflight_count(inf_a), .stall_cycles(sc_a), .stat_clear(clr_a),
        .protocol_error(err_a)
    );

    nfc_sim_pipelined #(
        .NFC_DELAY(D), .MAX_INFLIGHT(DEPTH), .PAUSE_UNIT(PU), .TREADY_GAP(0), .STAT_W(SW)
    ) u_dut_b (
        .clk(clk), .rst(rst), .nfc(nfc_b), .stall_transmission(stall_b),
        .inflight_count(inf_b), .stall_cycles(sc_b), .stat_clear(clr_b),
        .protocol_error(err_b)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
    } sb_t;

    sb_t           sb_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            m_state;
    int            m_cnt;
    logic [SW-1:0] m_sc;
    logic          m_err;
    logic          last_acc;
    logic          last_rdy;
    logic [2:0]    last_inf;
    logic          stall_hist [0:127];

    task automatic m_reset();
        sb_q.delete();
        m_state = M_RUN;
        m_cnt   = 0;
        m_sc    = '0;
        m_err   = 1'b0;
        cyc     = 0;
    endtask

    task automatic m_apply(input logic [15:0] d);
        if (d[8]) begin
            m_state = M_STOP;
        end else if (d[7:0] == 8'd0) begin
            m_state = M_RUN;
        end else if (m_state != M_STOP) begin
            m_state = M_PAUSE;
            m_cnt   = int'(d[7:0]) * PU;
        end
    endtask

    task automatic drive_idle();
        nfc_a.s_axi_nfc_tvalid = 1'b0;
        nfc_a.s_axi_nfc_tdata  = '0;
        nfc_b.s_axi_nfc_tvalid = 1'b0;
        nfc_b.s_axi_nfc_tdata  = '0;
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        release_reset();
    endtask

    // One clock: drive at the falling edge, model the rising edge, compare at the next fall.
    task automatic tick(input int sel, input logic v, input logic [15:0] d, input logic clr);
        logic          rdy, acc, prev_stall, exp_stall, s_stall, s_err;
        logic [2:0]    s_inf;
        logic [SW-1:0] s_sc;
        sb_t           e;
        if (sel == 0) begin
            nfc_a.s_axi_nfc_tvalid = v;
            nfc_a.s_axi_nfc_tdata  = d;
            clr_a = clr;
            rdy = nfc_a.s_axi_nfc_tready;
        end else begin
            nfc_b.s_axi_nfc_tvalid = v;
            nfc_b.s_axi_nfc_tdata  = d;
            clr_b = clr;
            rdy = nfc_b.s_axi_nfc_tready;
        end
        acc      = v && rdy;
        last_acc = acc;
        last_rdy = rdy;
        @(posedge clk);
        prev_stall = (m_state != M_RUN);
        if (clr) m_sc = '0;
        else if (prev_stall && (m_sc != '1)) m_sc = m_sc + 1;
        if (clr) m_err = 1'b0;
        else if (acc && (d[15:9] != 7'd0)) m_err = 1'b1;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            m_apply(e.data);
        end else if (m_state == M_PAUSE) begin
            if (m_cnt <= 1) m_state = M_RUN;
            else m_cnt = m_cnt - 1;
        end
        if (acc) begin
            e.due  = cyc + int'(D) + 1;
            e.data = d;
            sb_q.push_back(e);
        end
        @(negedge clk);
        s_stall = (sel == 0) ? stall_a : stall_b;
        s_inf   = (sel == 0) ? inf_a : inf_b;
        s_sc    = (sel == 0) ? sc_a : sc_b;
        s_err   = (sel == 0) ? err_a : err_b;
        last_inf = s_inf;
        if (cyc < 128) stall_hist[cyc] = s_stall;
        exp_stall = (m_state != M_RUN);
        checks++;
        if (s_stall !== exp_stall) begin
            errors++;
            $display("FAIL stall cyc %0d got %b exp %b", cyc, s_stall, exp_stall);
        end
        checks++;
        if (s_inf !== 3'(sb_q.size())) begin
            errors++;
            $display("FAIL inflight cyc %0d got %0d exp %0d", cyc, s_inf, sb_q.size());
        end
        checks++;
        if (s_sc !== m_sc) begin
            errors++;
            $display("FAIL stall_cycles cyc %0d got %0d exp %0d", cyc, s_sc, m_sc);
        end
        checks++;
        if (s_err !== m_err) begin
            errors++;
            $display("FAIL protocol_error cyc %0d got %b exp %b", cyc, s_err, m_err);
        end
        cyc++;
    endtask

    task automatic check_hist(input string name, input int idx, input logic exp);
        checks++;
        if (stall_hist[idx] !== exp) begin
            errors++;
            $display("FAIL %s stall at cycle %0d got %b exp %b", name, idx, stall_hist[idx], exp);
        end
    endtask

    task automatic check_acc(input string name, input logic exp);
        checks++;
        if (last_acc !== exp) begin
            errors++;
            $display("FAIL %s accept at edge %0d got %b exp %b", name, cyc - 1, last_acc, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({stall_a, stall_b, err_a, err_b} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000", {stall_a, stall_b, err_a, err_b});
        end
        checks++;
        if ({inf_a, inf_b} !== 6'd0 || sc_a !== '0 || sc_b !== '0) begin
            errors++;
            $display("FAIL reset_counts got %0d/%0d/%0d/%0d exp 0", inf_a, inf_b, sc_a, sc_b);
        end
        checks++;
        if ({nfc_a.s_axi_nfc_tready, nfc_b.s_axi_nfc_tready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_tready got %b%b exp 11",
                     nfc_a.s_axi_nfc_tready, nfc_b.s_axi_nfc_tready);
        end
        release_reset();
    endtask

    task automatic test_pause();
        logic v;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            v = (i == 10);
            tick(0, v, 16'h0008, 1'b0);
            if (v) check_acc("pause", 1'b1);
        end
        check_hist("pause", 26, 1'b0);
        check_hist("pause", 27, 1'b1);
        check_hist("pause", 34, 1'b1);
        check_hist("pause", 35, 1'b0);
        checks++;
        if (sc_a !== 32'd8) begin
            errors++;
            $display("FAIL pause_stall_cycles got %0d exp 8", sc_a);
        end
    endtask

    task automatic test_xoff_xon();
        logic v;
        logic [15:0] d;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            v = (i == 0) || (i == 5);
            d = (i == 0) ? 16'h0100 : 16'h0000;
            tick(0, v, d, 1'b0);
            if (v) check_acc("xoff_xon", 1'b1);
        end
        check_hist("xoff_xon", 16, 1'b0);
        check_hist("xoff_xon", 17, 1'b1);
        check_hist("xoff_xon", 21, 1'b1);
        check_hist("xoff_xon", 22, 1'b0);
        check_hist("xoff_xon", 29, 1'b0);
    endtask

    task automatic test_reload();
        logic v;
        logic [15:0] d;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            v = (i == 0) || (i == 10);
            d = (i == 0) ? 16'h0014 : 16'h0004;
            tick(0, v, d, 1'b0);
            if (v) check_acc("reload", 1'b1);
        end
        check_hist("reload", 16, 1'b0);
        check_hist("reload", 17, 1'b1);
        check_hist("reload", 30, 1'b1);
        check_hist("reload", 31, 1'b0);
        checks++;
        if (sc_a !== 32'd14) begin
            errors++;
            $display("FAIL reload_stall_cycles got %0d exp 14", sc_a);
        end
    endtask

    task automatic test_back_to_back();
        int peak = 0;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            tick(1, 1'b1, 16'h0000, 1'b0);
            if (int'(last_inf) > peak) peak = int'(last_inf);
            if (i <= 3 || i == 17) check_acc("b2b", 1'b1);
            else if (i >= 4 && i <= 16) check_acc("b2b", 1'b0);
        end
        checks++;
        if (peak != 4) begin
            errors++;
            $display("FAIL b2b_peak_inflight got %0d exp 4", peak);
        end
    endtask

    task automatic test_protocol_error();
        do_reset();
        tick(0, 1'b1, 16'h0300, 1'b0);
        check_acc("proto", 1'b1);
        checks++;
        if (err_a !== 1'b1) begin
            errors++;
            $display("FAIL proto_error_set got %b exp 1", err_a);
        end
        for (int i = 1; i < 25; i++) tick(0, 1'b0, 16'h0000, 1'b0);
        check_hist("proto", 17, 1'b1);
        tick(0, 1'b0, 16'h0000, 1'b1);
        checks++;
        if (sc_a !== '0 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL proto_clear got sc %0d err %b exp sc 0 err 0", sc_a, err_a);
        end
        tick(0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_reset_midop();
        logic v;
        logic [15:0] d;
        int late = 0;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            v = (i == 0) || (i == 8) || (i == 10) || (i == 12);
            d = (i == 0) ? 16'h001E : ((i == 10) ? 16'h0100 : 16'h0005);
            tick(0, v, d, 1'b0);
        end
        checks++;
        if (stall_a !== 1'b1 || inf_a !== 3'd3) begin
            errors++;
            $display("FAIL midop_pre got stall %b inflight %0d exp 1 3", stall_a, inf_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (stall_a !== 1'b0 || inf_a !== 3'd0) begin
            errors++;
            $display("FAIL midop_async got stall %b inflight %0d exp 0 0", stall_a, inf_a);
        end
        drive_idle();
        release_reset();
        for (int i = 0; i < 40; i++) begin
            tick(0, 1'b0, 16'h0000, 1'b0);
            if (stall_hist[i] !== 1'b0) late++;
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL midop_late_stall got %0d stall cycles exp 0", late);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pause();
        test_xoff_xon();
        test_reload();
        test_back_to_back();
        test_protocol_error();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
